// File: rtl/cache_fill_sequencer_if.sv
// Request/fill/memory-bus signal bundle for cache_fill_sequencer.
// master = the sequencer, slave = the L1 requesters plus memory bus it talks to.
interface cache_fill_sequencer_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int BUS_DW  = 64,
  parameter int BUS_TW  = 13,
  parameter int BEATS   = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      fill_valid;
  logic [ID_W-1:0]           fill_id;
  logic [ADDR_W-1:0]         fill_addr;
  logic [BEATS*BUS_DW-1:0]   fill_line;
  logic                      busy;
  logic                      bus_reqcyc;
  logic                      bus_reqack;
  logic [BUS_DW-1:0]         bus_req;
  logic [BUS_TW-1:0]         bus_reqtag;
  logic                      bus_respcyc;
  logic                      bus_respack;
  logic [BUS_DW-1:0]         bus_resp;
  logic [BUS_TW-1:0]         bus_resptag;

  modport master (
    input  req_valid, req_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output req_grant, fill_valid, fill_id, fill_addr, fill_line, busy,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport slave (
    output req_valid, req_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  req_grant, fill_valid, fill_id, fill_addr, fill_line, busy,
           bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/cache_fill_sequencer.sv
// Arbitrates L1 line-fill misses onto one memory bus and assembles BEATS beats into a line.
// Define FILL_ARB_RR_EN for round-robin arbitration; default is fixed priority 0 > 1 > 2.
module cache_fill_sequencer #(
  parameter int                NUM_REQ  = 3,
  parameter int                ADDR_W   = 64,
  parameter int                BUS_DW   = 64,
  parameter int                BUS_TW   = 13,
  parameter int                BEATS    = 8,
  parameter logic [BUS_TW-1:0] MEM_READ = BUS_TW'(1)
) (
  input logic                    clk,
  input logic                    reset,
  cache_fill_sequencer_if.master io
);
  localparam int ID_W  = 2;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BEAT, ST_DONE} state_t;

  state_t                  state_q;
  logic [NUM_REQ-1:0]      req_grant_q;
  logic                    fill_valid_q;
  logic [ID_W-1:0]         fill_id_q;
  logic [ADDR_W-1:0]       fill_addr_q;
  logic [BEATS*BUS_DW-1:0] fill_line_q;
  logic                    bus_reqcyc_q;
  logic [BUS_DW-1:0]       bus_req_q;
  logic [BUS_TW-1:0]       bus_reqtag_q;
  logic                    bus_respack_q;
  logic [ID_W-1:0]         id_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [ADDR_W-1:0]       req_addr_arr [NUM_REQ];
  logic [BEATS*BUS_DW-1:0] line_d;
  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic                    beat_accept;
  logic                    last_beat;

  assign beat_accept = (state_q == ST_BEAT) && io.bus_respcyc && (io.bus_resptag == MEM_READ);
  assign last_beat   = (cnt_q == CNT_W'(BEATS - 1));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign req_addr_arr[gi] = io.req_addr[gi*ADDR_W +: ADDR_W];
  end

  // line_d already contains the beat being accepted this cycle, so the final
  // beat can be folded straight into fill_line_q on the same edge.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    logic              hit;
    logic [BUS_DW-1:0] beat_q;
    assign hit = beat_accept && (cnt_q == CNT_W'(gi));
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        beat_q <= '0;
      end else if (hit) begin
        beat_q <= io.bus_resp;
      end
    end
    assign line_d[gi*BUS_DW +: BUS_DW] = hit ? io.bus_resp : beat_q;
  end

`ifdef FILL_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] rr_next;
  int              rr_cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && io.req_valid[rr_cand]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(rr_cand);
      end
    end
  end

  assign rr_next = ID_W'((int'(win_idx) + 1) % NUM_REQ);
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (io.req_valid[k]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_grant_q   <= '0;
      fill_valid_q  <= 1'b0;
      fill_id_q     <= '0;
      fill_addr_q   <= '0;
      fill_line_q   <= '0;
      bus_reqcyc_q  <= 1'b0;
      bus_req_q     <= '0;
      bus_reqtag_q  <= '0;
      bus_respack_q <= 1'b0;
      id_q          <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
`ifdef FILL_ARB_RR_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      req_grant_q   <= '0;
      fill_valid_q  <= 1'b0;
      bus_respack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            req_grant_q <= NUM_REQ'(1) << win_idx;
            id_q        <= win_idx;
            addr_q      <= req_addr_arr[win_idx] & ~ADDR_W'(63);
            state_q     <= ST_REQ;
`ifdef FILL_ARB_RR_EN
            rr_ptr_q    <= rr_next;
`endif
          end
        end
        // First REQ cycle raises the request; an ack is only honoured once it is visible.
        ST_REQ: begin
          if (!bus_reqcyc_q) begin
            bus_reqcyc_q <= 1'b1;
            bus_req_q    <= BUS_DW'(addr_q);
            bus_reqtag_q <= MEM_READ;
          end else if (io.bus_reqack) begin
            bus_reqcyc_q <= 1'b0;
            bus_req_q    <= '0;
            bus_reqtag_q <= '0;
            state_q      <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (beat_accept) begin
            bus_respack_q <= 1'b1;
            if (last_beat) begin
              cnt_q        <= '0;
              fill_valid_q <= 1'b1;
              fill_id_q    <= id_q;
              fill_addr_q  <= addr_q;
              fill_line_q  <= line_d;
              state_q      <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign io.req_grant   = req_grant_q;
  assign io.fill_valid  = fill_valid_q;
  assign io.fill_id     = fill_id_q;
  assign io.fill_addr   = fill_addr_q;
  assign io.fill_line   = fill_line_q;
  assign io.busy        = (state_q != ST_IDLE);
  assign io.bus_reqcyc  = bus_reqcyc_q;
  assign io.bus_req     = bus_req_q;
  assign io.bus_reqtag  = bus_reqtag_q;
  assign io.bus_respack = bus_respack_q;
endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Directed self-checking bench for cache_fill_sequencer: one task per scenario, bus modelled inline.
module tb_cache_fill_sequencer;
  localparam logic [12:0] MEM_READ = 13'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_fill_sequencer_if bus_if ();
  cache_fill_sequencer dut (.clk(clk), .reset(reset), .io(bus_if));

  int checks   = 0;
  int failures = 0;

  logic [63:0]  beat_data [8];
  int           rb_timeout, rb_stable, rb_reqcyc_after, rb_acks, rb_missed, rb_extra;
  int           rb_fv_count, rb_fv_beat, rb_grants, rb_foreign_acks;
  logic [63:0]  rb_req;
  logic [12:0]  rb_tag;
  logic [1:0]   rb_fv_id;
  logic [63:0]  rb_fv_addr;
  logic [511:0] rb_fv_line;

  function automatic logic [511:0] pack_line();
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_data[k];
    return l;
  endfunction

  task automatic note(input int k);
    if (|bus_if.req_grant) rb_grants++;
    if (bus_if.fill_valid === 1'b1) begin
      rb_fv_count++;
      if (rb_fv_beat < 0) rb_fv_beat = k;
      rb_fv_id   = bus_if.fill_id;
      rb_fv_addr = bus_if.fill_addr;
      rb_fv_line = bus_if.fill_line;
    end
  endtask

  task automatic wait_grant();
    for (int w = 0; w < 10 && bus_if.req_grant === '0; w++) @(negedge clk);
  endtask

  // Memory-side model: waits for the request, acks after ack_delay cycles, returns beats.
  task automatic run_bus(input int ack_delay, input int gap, input int max_beats,
                         input int foreign_at, input int late_at);
    rb_timeout = 0; rb_stable = 0; rb_reqcyc_after = 0; rb_acks = 0; rb_missed = 0;
    rb_extra = 0; rb_fv_count = 0; rb_fv_beat = -1; rb_grants = 0; rb_foreign_acks = 0;
    rb_req = '0; rb_tag = '0; rb_fv_id = '0; rb_fv_addr = '0; rb_fv_line = '0;
    for (int w = 0; w < 20 && bus_if.bus_reqcyc !== 1'b1; w++) @(negedge clk);
    if (bus_if.bus_reqcyc !== 1'b1) begin
      rb_timeout = 1;
      return;
    end
    rb_req = bus_if.bus_req;
    rb_tag = bus_if.bus_reqtag;
    for (int i = 0; i < ack_delay; i++) begin
      if (bus_if.bus_reqcyc === 1'b1 && bus_if.bus_req === rb_req) rb_stable++;
      @(negedge clk);
    end
    bus_if.bus_reqack = 1'b1;
    @(negedge clk);
    bus_if.bus_reqack = 1'b0;
    rb_reqcyc_after = int'(bus_if.bus_reqcyc);
    for (int k = 0; k < max_beats; k++) begin
      if (k == late_at) begin
        bus_if.req_addr[64 +: 64] = 64'h6000;
        bus_if.req_valid[1] = 1'b1;
      end
      if (k == foreign_at) begin
        bus_if.bus_respcyc = 1'b1;
        bus_if.bus_resptag = MEM_READ ^ 13'h100;
        bus_if.bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        note(k);
        bus_if.bus_respcyc = 1'b0;
        @(negedge clk);
        if (bus_if.bus_respack === 1'b1) rb_foreign_acks++;
        note(k);
      end
      bus_if.bus_respcyc = 1'b1;
      bus_if.bus_resptag = MEM_READ;
      bus_if.bus_resp    = beat_data[k];
      @(negedge clk);
      if (bus_if.bus_respack === 1'b1) rb_acks++; else rb_missed++;
      note(k);
      bus_if.bus_respcyc = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (bus_if.bus_respack === 1'b1) rb_extra++;
        note(k);
      end
    end
  endtask

  task automatic test_reset();
    bus_if.req_valid = '0; bus_if.req_addr = '0; bus_if.bus_reqack = 1'b0;
    bus_if.bus_respcyc = 1'b0; bus_if.bus_resp = '0; bus_if.bus_resptag = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    checks++; if (bus_if.bus_reqcyc !== 1'b0 || bus_if.bus_req !== '0 || bus_if.bus_reqtag !== '0) begin failures++; $display("FAIL reset_bus got=%b/%0h/%0h exp=0/0/0", bus_if.bus_reqcyc, bus_if.bus_req, bus_if.bus_reqtag); end
    checks++; if (bus_if.req_grant !== '0 || bus_if.fill_valid !== 1'b0 || bus_if.bus_respack !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b/%b/%b exp=0/0/0", bus_if.req_grant, bus_if.fill_valid, bus_if.bus_respack); end
    checks++; if (bus_if.fill_line !== '0 || bus_if.fill_addr !== '0 || bus_if.fill_id !== '0) begin failures++; $display("FAIL reset_fill got=%0h/%0h/%0d exp=0", bus_if.fill_line, bus_if.fill_addr, bus_if.fill_id); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.busy !== 1'b0 || bus_if.req_grant !== '0) begin failures++; $display("FAIL idle_no_req got=%b/%b exp=0/0", bus_if.busy, bus_if.req_grant); end
  endtask

  task automatic test_single_fill();
    bus_if.req_addr = '0;
    bus_if.req_addr[128 +: 64] = 64'h1047;
    bus_if.req_valid = 3'b100;
    @(negedge clk);
    checks++; if (bus_if.req_grant !== 3'b100) begin failures++; $display("FAIL single_grant got=%b exp=100", bus_if.req_grant); end
    checks++; if (bus_if.bus_reqcyc !== 1'b0 || bus_if.busy !== 1'b1) begin failures++; $display("FAIL single_grant_cycle got=reqcyc%b busy%b exp=reqcyc0 busy1", bus_if.bus_reqcyc, bus_if.busy); end
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'(8'h11 * (k + 1));
    run_bus(0, 0, 8, -1, -1);
    checks++; if (rb_timeout != 0 || rb_req !== 64'h1040 || rb_tag !== MEM_READ) begin failures++; $display("FAIL single_req got=to%0d addr%0h tag%0h exp=to0 addr1040 tag%0h", rb_timeout, rb_req, rb_tag, MEM_READ); end
    checks++; if (rb_reqcyc_after != 0) begin failures++; $display("FAIL single_reqcyc_drop got=%0d exp=0", rb_reqcyc_after); end
    checks++; if (rb_acks != 8) begin failures++; $display("FAIL single_acks got=%0d exp=8", rb_acks); end
    checks++; if (rb_fv_count != 1 || rb_fv_beat != 7) begin failures++; $display("FAIL single_fill_pulse got=count%0d beat%0d exp=count1 beat7", rb_fv_count, rb_fv_beat); end
    checks++; if (rb_fv_id !== 2'd2 || rb_fv_addr !== 64'h1040) begin failures++; $display("FAIL single_id_addr got=%0d/%0h exp=2/1040", rb_fv_id, rb_fv_addr); end
    checks++; if (rb_fv_line[63:0] !== 64'h11 || rb_fv_line[511:448] !== 64'h88) begin failures++; $display("FAIL single_beats07 got=%0h/%0h exp=11/88", rb_fv_line[63:0], rb_fv_line[511:448]); end
    checks++; if (rb_fv_line !== pack_line()) begin failures++; $display("FAIL single_line got=%0h exp=%0h", rb_fv_line, pack_line()); end
    checks++; if (rb_grants != 0) begin failures++; $display("FAIL single_grant_overlap got=%0d exp=0", rb_grants); end
    @(negedge clk);
    checks++; if (bus_if.fill_valid !== 1'b0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL single_after got=fv%b busy%b exp=fv0 busy0", bus_if.fill_valid, bus_if.busy); end
    checks++; if (bus_if.fill_addr !== 64'h1040) begin failures++; $display("FAIL single_hold got=%0h exp=1040", bus_if.fill_addr); end
  endtask

  task automatic test_contention();
    logic [63:0] exp_addr [3];
    exp_addr[0] = 64'h1000_0040; exp_addr[1] = 64'h2000_00C0; exp_addr[2] = 64'h3000_0100;
    bus_if.req_addr = {64'h3000_0123, 64'h2000_00FF, 64'h1000_0040};
    bus_if.req_valid = 3'b111;
    for (int n = 0; n < 3; n++) begin
      wait_grant();
      checks++; if (bus_if.req_grant !== (3'b001 << n)) begin failures++; $display("FAIL contention_grant%0d got=%b exp=%b", n, bus_if.req_grant, 3'b001 << n); end
      bus_if.req_valid = bus_if.req_valid & ~bus_if.req_grant;
      for (int k = 0; k < 8; k++) beat_data[k] = 64'(32'hC000_0000 + n * 16 + k);
      run_bus(0, 0, 8, -1, -1);
      checks++; if (rb_fv_id !== 2'(n) || rb_fv_addr !== exp_addr[n]) begin failures++; $display("FAIL contention_fill%0d got=%0d/%0h exp=%0d/%0h", n, rb_fv_id, rb_fv_addr, n, exp_addr[n]); end
      checks++; if (rb_fv_line !== pack_line()) begin failures++; $display("FAIL contention_line%0d got=%0h exp=%0h", n, rb_fv_line, pack_line()); end
      @(negedge clk);
    end
  endtask

  task automatic test_held_requests();
    int exp_seq [4];
`ifdef FILL_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    bus_if.req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_grant();
      checks++; if (bus_if.req_grant !== (3'b001 << exp_seq[n])) begin failures++; $display("FAIL held_grant%0d got=%b exp=%b", n, bus_if.req_grant, 3'b001 << exp_seq[n]); end
      if (n == 3) bus_if.req_valid = '0;
      for (int k = 0; k < 8; k++) beat_data[k] = 64'(n * 256 + k);
      run_bus(0, 0, 8, -1, -1);
      checks++; if (rb_fv_id !== 2'(exp_seq[n])) begin failures++; $display("FAIL held_id%0d got=%0d exp=%0d", n, rb_fv_id, exp_seq[n]); end
      @(negedge clk);
    end
  endtask

  task automatic test_handshake();
    bus_if.req_addr = '0;
    bus_if.req_addr[0 +: 64] = 64'h2000_0000_0FC0;
    bus_if.req_valid = 3'b001;
    wait_grant();
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'hA0A0_0000_0000_0000 | 64'(k);
    run_bus(5, 3, 8, -1, -1);
    checks++; if (rb_timeout != 0 || rb_stable != 5) begin failures++; $display("FAIL handshake_stable got=to%0d stable%0d exp=to0 stable5", rb_timeout, rb_stable); end
    checks++; if (rb_req !== 64'h2000_0000_0FC0) begin failures++; $display("FAIL handshake_addr got=%0h exp=20000000fc0", rb_req); end
    checks++; if (rb_acks != 8 || rb_missed != 0 || rb_extra != 0) begin failures++; $display("FAIL handshake_acks got=%0d/%0d/%0d exp=8/0/0", rb_acks, rb_missed, rb_extra); end
    checks++; if (rb_fv_count != 1 || rb_fv_line !== pack_line()) begin failures++; $display("FAIL handshake_line got=count%0d %0h exp=count1 %0h", rb_fv_count, rb_fv_line, pack_line()); end
    @(negedge clk);
  endtask

  task automatic test_foreign_tag();
    bus_if.req_addr = '0;
    bus_if.req_addr[0 +: 64] = 64'h7000;
    bus_if.req_valid = 3'b001;
    wait_grant();
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'h0F0F_0000_0000_0000 | 64'(k * 3);
    run_bus(0, 0, 8, 3, -1);
    checks++; if (rb_foreign_acks != 0) begin failures++; $display("FAIL foreign_ack got=%0d exp=0", rb_foreign_acks); end
    checks++; if (rb_acks != 8 || rb_fv_beat != 7 || rb_fv_count != 1) begin failures++; $display("FAIL foreign_count got=acks%0d beat%0d count%0d exp=acks8 beat7 count1", rb_acks, rb_fv_beat, rb_fv_count); end
    checks++; if (rb_fv_line !== pack_line()) begin failures++; $display("FAIL foreign_line got=%0h exp=%0h", rb_fv_line, pack_line()); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    int fv_seen;
    bus_if.req_addr = '0;
    bus_if.req_addr[0 +: 64] = 64'h8000;
    bus_if.req_valid = 3'b001;
    wait_grant();
    bus_if.req_valid = '0;
    for (int w = 0; w < 5 && bus_if.bus_reqcyc !== 1'b1; w++) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus_if.bus_reqcyc !== 1'b0 || bus_if.bus_req !== '0 || bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_in_req got=%b/%0h/%b exp=0/0/0", bus_if.bus_reqcyc, bus_if.bus_req, bus_if.busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_if.req_addr[64 +: 64] = 64'h3000;
    bus_if.req_valid = 3'b010;
    wait_grant();
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'h5000 + 64'(k);
    run_bus(0, 0, 4, -1, -1);
    checks++; if (rb_acks != 4 || rb_fv_count != 0) begin failures++; $display("FAIL partial_fill got=acks%0d fv%0d exp=acks4 fv0", rb_acks, rb_fv_count); end
    reset = 1'b1;
    #1;
    checks++; if (bus_if.busy !== 1'b0 || bus_if.bus_respack !== 1'b0 || bus_if.fill_valid !== 1'b0) begin failures++; $display("FAIL reset_in_beat got=%b/%b/%b exp=0/0/0", bus_if.busy, bus_if.bus_respack, bus_if.fill_valid); end
    checks++; if (bus_if.fill_line !== '0) begin failures++; $display("FAIL reset_line got=%0h exp=0", bus_if.fill_line); end
    @(negedge clk);
    reset = 1'b0;
    fv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_if.fill_valid === 1'b1) fv_seen++;
    end
    checks++; if (fv_seen != 0) begin failures++; $display("FAIL reset_no_fill got=%0d exp=0", fv_seen); end
    bus_if.req_addr[64 +: 64] = 64'h4000;
    bus_if.req_valid = 3'b010;
    wait_grant();
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'h9000 + 64'(k);
    run_bus(0, 0, 8, -1, -1);
    checks++; if (rb_fv_beat != 7 || rb_fv_id !== 2'd1 || rb_fv_addr !== 64'h4000) begin failures++; $display("FAIL refill_pulse got=beat%0d id%0d addr%0h exp=beat7 id1 addr4000", rb_fv_beat, rb_fv_id, rb_fv_addr); end
    checks++; if (rb_fv_line !== pack_line()) begin failures++; $display("FAIL refill_line got=%0h exp=%0h", rb_fv_line, pack_line()); end
    @(negedge clk);
  endtask

  task automatic test_late_request();
    bus_if.req_addr = '0;
    bus_if.req_addr[0 +: 64] = 64'h5000;
    bus_if.req_valid = 3'b001;
    wait_grant();
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'h7700 + 64'(k);
    run_bus(0, 0, 8, -1, 2);
    checks++; if (rb_grants != 0) begin failures++; $display("FAIL late_no_grant got=%0d exp=0", rb_grants); end
    checks++; if (rb_fv_id !== 2'd0 || rb_fv_addr !== 64'h5000) begin failures++; $display("FAIL late_first_fill got=%0d/%0h exp=0/5000", rb_fv_id, rb_fv_addr); end
    wait_grant();
    checks++; if (bus_if.req_grant !== 3'b010 || bus_if.fill_valid !== 1'b0) begin failures++; $display("FAIL late_grant got=%b fv%b exp=010 fv0", bus_if.req_grant, bus_if.fill_valid); end
    bus_if.req_valid = '0;
    for (int k = 0; k < 8; k++) beat_data[k] = 64'h6600 + 64'(k);
    run_bus(0, 0, 8, -1, -1);
    checks++; if (rb_fv_id !== 2'd1 || rb_fv_addr !== 64'h6000) begin failures++; $display("FAIL late_second_fill got=%0d/%0h exp=1/6000", rb_fv_id, rb_fv_addr); end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fill();
    test_contention();
    test_held_requests();
    test_handshake();
    test_foreign_tag();
    test_reset_mid_fill();
    test_late_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
